// File: rtl/saturn_debug_pkg.sv
// Shared FSM encoding, ASCII constants and hex rendering for the debug word transmitter.
// SATURN_DEBUG_TX_CRLF_EN selects a CR/LF terminator instead of a single space.
package saturn_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  localparam logic [7:0] CHR_CR        = 8'h0D;
  localparam logic [7:0] CHR_LF        = 8'h0A;
  localparam logic [7:0] CHR_SP        = 8'h20;
  localparam logic [7:0] CHR_0         = 8'h30;
  localparam logic [7:0] HEX_ALPHA_OFS = 8'h37;

`ifdef SATURN_DEBUG_TX_CRLF_EN
  localparam int TERM_CHARS = 2;
`else
  localparam int TERM_CHARS = 1;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (CHR_0 + {4'h0, n}) : (HEX_ALPHA_OFS + {4'h0, n});
  endfunction

endpackage

// File: rtl/saturn_debug_tx_if.sv
// Trace-side word push and serial-TX character handshake of saturn_debug_tx.
interface saturn_debug_tx_if #(
  parameter int WORD_NIBBLES = 5
);

  logic [4*WORD_NIBBLES-1:0] i_word;
  logic                      i_word_valid;
  logic                      o_word_ready;
  logic [7:0]                o_char_to_send;
  logic                      o_char_valid;
  logic                      i_serial_busy;
  logic [7:0]                o_drop_count;
  logic                      o_idle;

  modport slave (
    input  i_word, i_word_valid, i_serial_busy,
    output o_word_ready, o_char_to_send, o_char_valid, o_drop_count, o_idle
  );

  modport master (
    output i_word, i_word_valid, i_serial_busy,
    input  o_word_ready, o_char_to_send, o_char_valid, o_drop_count, o_idle
  );

endinterface

// File: rtl/saturn_debug_fifo.sv
// Word FIFO, depth 2^AW; pushes while full and pops while empty are ignored.
module saturn_debug_fifo #(
  parameter int WIDTH = 20,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is taken from the registered count, so a same-cycle pop never makes room.
  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/saturn_debug_tx.sv
// Buffers trace words and streams each as uppercase hex digits plus terminator to the serial TX.
// SATURN_DEBUG_TX_CRLF_EN: terminate each word with CR LF instead of a space.
module saturn_debug_tx
  import saturn_debug_pkg::*;
#(
  parameter int FIFO_AW      = 3,
  parameter int WORD_NIBBLES = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  saturn_debug_tx_if.slave  bus
);

  localparam int WORD_W = 4 * WORD_NIBBLES;
  localparam int CHARS  = WORD_NIBBLES + TERM_CHARS;
  localparam int IDX_W  = $clog2(CHARS + 1);

  localparam logic [IDX_W-1:0] NIB_CNT  = IDX_W'(WORD_NIBBLES);
  localparam logic [IDX_W-1:0] NIB_LAST = IDX_W'(WORD_NIBBLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS - 1);

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   sh, sh_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [7:0]          chr, chr_nxt;
  logic [7:0]          drop_cnt;
  logic                char_valid;
  logic                pop;
  logic                full;
  logic                empty;
  logic [WORD_W-1:0]   head;

  function automatic logic [7:0] char_at(input logic [IDX_W-1:0] i,
                                         input logic [WORD_W-1:0] s);
    if (i < NIB_CNT) return hex_char(s[WORD_W-1 -: 4]);
`ifdef SATURN_DEBUG_TX_CRLF_EN
    if (i == NIB_CNT) return CHR_CR;
    return CHR_LF;
`else
    return CHR_SP;
`endif
  endfunction

  saturn_debug_fifo #(
    .WIDTH (WORD_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .push  (bus.i_word_valid),
    .pop   (pop),
    .din   (bus.i_word),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // The next character is latched on entry to SEND so it is steady through WAIT_DONE.
  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    idx_nxt    = idx;
    chr_nxt    = chr;
    pop        = 1'b0;
    char_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        pop       = 1'b1;
        sh_nxt    = head;
        idx_nxt   = '0;
        chr_nxt   = char_at('0, head);
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (!bus.i_serial_busy) begin
          char_valid = 1'b1;
          state_nxt  = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (bus.i_serial_busy) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!bus.i_serial_busy) begin
          if (idx < LAST_IDX) begin
            idx_nxt = idx + 1'b1;
            if (idx < NIB_LAST) sh_nxt = sh << 4;
            chr_nxt   = char_at(idx_nxt, sh_nxt);
            state_nxt = ST_SEND;
          end else if (!empty) begin
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      chr      <= CHR_SP;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      chr   <= chr_nxt;
      if (bus.i_word_valid && full && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    sh <= sh_nxt;
  end

  assign bus.o_word_ready   = !full;
  assign bus.o_char_valid   = char_valid;
  assign bus.o_char_to_send = chr;
  assign bus.o_drop_count   = drop_cnt;
  assign bus.o_idle         = (state == ST_IDLE) && empty;

endmodule

// File: tb/tb_saturn_debug_tx.sv
// Self-checking bench for saturn_debug_tx: word-queue/character-stream model plus directed literal checks.
module tb_saturn_debug_tx;

`ifdef SATURN_DEBUG_TX_CRLF_EN
  localparam int CH = 7;
`else
  localparam int CH = 6;
`endif
  localparam int DEPTH    = 8;
  localparam int BUSY_LEN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  saturn_debug_tx_if #(.WORD_NIBBLES(5)) bus ();

  saturn_debug_tx #(.FIFO_AW(3), .WORD_NIBBLES(5)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial TX stand-in: busy rises the cycle after a strobe and stays high BUSY_LEN cycles.
  logic hold = 1'b0;
  int   scnt = 0;
  logic vpre;
  initial begin
    bus.i_serial_busy = 1'b0;
    forever begin
      @(posedge clk);
      vpre = bus.o_char_valid;
      #2;
      if (vpre) scnt = BUSY_LEN;
      else if (scnt > 0) scnt--;
      bus.i_serial_busy = hold || (scnt > 0);
    end
  end

  // Behavioural model: word queue, expected char stream, printer phase.
  logic [19:0] mq[$];
  logic [7:0]  exp_chars[$];
  logic [7:0]  rx[$];
  logic [7:0]  expv[$];
  int  m_phase = 0;   // 0 idle, 1 load, 2 printing a word
  int  left    = 0;
  int  wstage  = 0;   // after last char: 1 awaiting busy, 2 awaiting busy low
  int  m_drop  = 0;
  int  sz;
  bit  prev_valid = 0;
  logic [19:0] w;

  function automatic void add_term(ref logic [7:0] q[$]);
`ifdef SATURN_DEBUG_TX_CRLF_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`else
    q.push_back(8'h20);
`endif
  endfunction

  function automatic void render(input logic [19:0] wd);
    for (int i = 4; i >= 0; i--) begin
      int d;
      d = int'((wd >> (4 * i)) & 20'hF);
      exp_chars.push_back(d < 10 ? 8'(48 + d) : 8'(65 + d - 10));
    end
    add_term(exp_chars);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_chars.delete();
      m_phase    = 0;
      left       = 0;
      wstage     = 0;
      m_drop     = 0;
      prev_valid = 0;
    end else begin
      sz = mq.size();
      if (bus.o_char_valid) begin
        chk("valid_while_busy", 32'(bus.i_serial_busy), 32'd0);
        chk("valid_back_to_back", 32'(prev_valid), 32'd0);
        if (exp_chars.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL char_unexpected: got %02h expected no strobe", bus.o_char_to_send);
        end else begin
          chk("char", 32'(bus.o_char_to_send), 32'(exp_chars.pop_front()));
        end
        rx.push_back(bus.o_char_to_send);
      end
      case (m_phase)
        0: if (sz > 0) m_phase = 1;
        1: begin
          w = mq.pop_front();
          render(w);
          left    = CH;
          wstage  = 0;
          m_phase = 2;
        end
        default: begin
          if (bus.o_char_valid) begin
            left--;
            if (left == 0) wstage = 1;
          end else if (wstage == 1) begin
            if (bus.i_serial_busy) wstage = 2;
          end else if (wstage == 2 && !bus.i_serial_busy) begin
            m_phase = (sz > 0) ? 1 : 0;
          end
        end
      endcase
      if (bus.i_word_valid) begin
        if (sz >= DEPTH) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else mq.push_back(bus.i_word);
      end
      prev_valid = bus.o_char_valid;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("word_ready", 32'(bus.o_word_ready), 32'(mq.size() < DEPTH));
      chk("drop_count", 32'(bus.o_drop_count), 32'(m_drop));
      chk("idle", 32'(bus.o_idle), 32'(m_phase == 0 && mq.size() == 0));
    end
  end

  task automatic push(input logic [19:0] wd);
    bus.i_word       = wd;
    bus.i_word_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_word_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(bus.o_idle && !bus.i_serial_busy && exp_chars.size() == 0 && mq.size() == 0)
           && n < budget) begin
      cycles(1);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", name, n);
    end
  endtask

  task automatic wait_rx(input string name, input int cnt);
    int n = 0;
    while (rx.size() < cnt && n < 500) begin
      cycles(1);
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d chars expected %0d", name, rx.size(), cnt);
    end
  endtask

  task automatic check_rx(input string name);
    chk({name, "_len"}, 32'(rx.size()), 32'(expv.size()));
    for (int i = 0; i < expv.size() && i < rx.size(); i++) chk(name, 32'(rx[i]), 32'(expv[i]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_word       = '0;
    bus.i_word_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_char", 32'(bus.o_char_to_send), 32'h20);
    chk("rst_valid", 32'(bus.o_char_valid), 32'd0);
    chk("rst_drop", 32'(bus.o_drop_count), 32'd0);
    chk("rst_ready", 32'(bus.o_word_ready), 32'd1);
    chk("rst_idle", 32'(bus.o_idle), 32'd1);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Test 1: single word, latency of first strobe, char sequence
    rx.delete();
    push(20'h1A2F3);
    @(negedge clk); chk("lat_c1", 32'(bus.o_char_valid), 32'd0);
    @(negedge clk); chk("lat_c2", 32'(bus.o_char_valid), 32'd0);
    @(negedge clk); chk("lat_c3", 32'(bus.o_char_valid), 32'd1);
    cycles(1);
    wait_idle("t1", 500);
    expv = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h33};
    add_term(expv);
    check_rx("t1_chars");
    chk("t1_idle", 32'(bus.o_idle), 32'd1);

    // Test 2: back-to-back all-zero and all-ones words
    rx.delete();
    push(20'h00000);
    push(20'hFFFFF);
    wait_idle("t2", 500);
    expv = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
    add_term(expv);
    for (int i = 0; i < 5; i++) expv.push_back(8'h46);
    add_term(expv);
    check_rx("t2_chars");

    // Test 3: printer stalled on one word, then 10 pushes into the FIFO
    rx.delete();
    hold = 1'b1;
    push(20'hABCDE);
    cycles(3);
    for (int i = 0; i < 10; i++) begin
      push(20'h10000 + 20'(i));
      if (i == 6) chk("t3_ready_at7", 32'(bus.o_word_ready), 32'd1);
      if (i == 7) chk("t3_ready_at8", 32'(bus.o_word_ready), 32'd0);
    end
    chk("t3_drop", 32'(bus.o_drop_count), 32'd2);

    // Test 4: drop counter saturation
    for (int i = 0; i < 300; i++) push(20'h0F000 + 20'(i));
    chk("t4_drop_sat", 32'(bus.o_drop_count), 32'hFF);
    hold = 1'b0;
    wait_idle("t3", 4000);
    expv = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    add_term(expv);
    for (int i = 0; i < 8; i++) begin
      expv.push_back(8'h31);
      expv.push_back(8'h30);
      expv.push_back(8'h30);
      expv.push_back(8'h30);
      expv.push_back(8'(8'h30 + i));
      add_term(expv);
    end
    check_rx("t3_chars");

    // Test 5: push coincides with the pop at count 3
    rx.delete();
    push(20'h76543);
    wait_rx("t5_first", CH);
    hold = 1'b1;
    rx.delete();
    for (int i = 0; i < 3; i++) push(20'hBEEF0 + 20'(i));
    hold = 1'b0;
    cycles(1);
    hold = 1'b1;
    push(20'hD00D0);
    for (int i = 1; i < 5; i++) push(20'hD00D0 + 20'(i));
    chk("t5_ready_at7", 32'(bus.o_word_ready), 32'd1);
    push(20'hD00D5);
    chk("t5_ready_at8", 32'(bus.o_word_ready), 32'd0);
    hold = 1'b0;
    wait_idle("t5", 4000);
    expv.delete();
    for (int i = 0; i < 3; i++) begin
      expv.push_back(8'h42); expv.push_back(8'h45); expv.push_back(8'h45);
      expv.push_back(8'h46); expv.push_back(8'(8'h30 + i));
      add_term(expv);
    end
    for (int i = 0; i < 6; i++) begin
      expv.push_back(8'h44); expv.push_back(8'h30); expv.push_back(8'h30);
      expv.push_back(8'h44); expv.push_back(8'(8'h30 + i));
      add_term(expv);
    end
    check_rx("t5_chars");

    // Test 6: asynchronous reset while waiting on the third character
    rx.delete();
    push(20'h2468A);
    push(20'h13579);
    push(20'h00ABC);
    wait_rx("t6_third", 3);
    cycles(1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.o_char_valid), 32'd0);
    chk("t6_drop", 32'(bus.o_drop_count), 32'd0);
    chk("t6_idle", 32'(bus.o_idle), 32'd1);
    chk("t6_ready", 32'(bus.o_word_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(BUSY_LEN + 2);
    rx.delete();
    push(20'hC0FFE);
    wait_idle("t6", 500);
    expv = '{8'h43, 8'h30, 8'h46, 8'h46, 8'h45};
    add_term(expv);
    check_rx("t6_chars");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
